vjtag_regbank: RTL and testbench
================================

// Module: vjtag_regbank
// PURPOSE
//   Parametrised virtual-JTAG register bank client behind the sld_virtual_jtag hub.
//   Provides BYPASS, ID, ADDR, DATA and STATUS data registers selected by the
//   virtual IR. DATA gives read/write access to NUM_REGS control registers at an
//   address with optional auto-increment. STATUS captures a fabric status word.
//   Control registers drive fabric outputs (LEDs, config bits).
// PARAMETERS
//   IR_WIDTH    3      width of ir_in
//   DR_WIDTH    8      width of ID/DATA/STATUS/ADDR scan chains and of each control reg
//   NUM_REGS    4      number of control registers (1..2**ADDR_WIDTH)
//   ADDR_WIDTH  2      address width; ADDR_WIDTH <= DR_WIDTH
//   ID_VALUE    8'hA5  constant captured by the ID register (DR_WIDTH bits)
//   AUTO_INC    1      1: address increments after each DATA update; 0: address holds
// PORTS
//   tck                input   1                     JTAG clock from hub; all state on posedge
//   rst                input   1                     async reset, active-high
//   tdi                input   1                     serial data in
//   tdo                output  1                     serial data out (combinational)
//   ir_in              input   IR_WIDTH              virtual instruction
//   virtual_state_cdr  input   1                     Capture-DR
//   virtual_state_sdr  input   1                     Shift-DR
//   virtual_state_udr  input   1                     Update-DR
//   status_in          input   DR_WIDTH              fabric status word, sampled on CDR
//   ctrl_out           output  NUM_REGS*DR_WIDTH     reg[i] at [i*DR_WIDTH +: DR_WIDTH]
//   update_strobe      output  1                     1-tck pulse after a DATA write
//   update_addr        output  ADDR_WIDTH            address of last DATA write
// BEHAVIOUR
//   - IR decode: 0 BYPASS, 1 ID, 2 ADDR, 3 DATA, 4 STATUS; other codes act as BYPASS.
//   - State: bypass_reg (1b), shift reg sr (DR_WIDTH), addr (ADDR_WIDTH), regs[NUM_REGS].
//   - Reset (async, rst=1): bypass_reg, sr, addr, all regs, update_strobe and
//     update_addr go to 0, so ctrl_out=0. tdo follows the mux (sr[0]=0 or bypass_reg=0).
//   - CDR, posedge tck: BYPASS: bypass_reg<=0. ID: sr<=ID_VALUE.
//     ADDR: sr<={0,addr}. DATA: sr<=regs[addr], or 0 if addr>=NUM_REGS.
//     STATUS: sr<=status_in.
//   - SDR, posedge tck: BYPASS: bypass_reg<=tdi. Others: sr<={tdi,sr[DR_WIDTH-1:1]}.
//     Shift is LSB first; one bit per cycle.
//   - tdo = bypass_reg for BYPASS/unused codes, else sr[0]. No extra latency.
//     BYPASS gives a 1-tck delay from tdi to tdo.
//   - UDR, posedge tck: ADDR: addr<=sr[ADDR_WIDTH-1:0]. ID, STATUS and BYPASS: no effect.
//   - UDR with DATA and addr<NUM_REGS: regs[addr]<=sr; update_addr<=addr;
//     update_strobe<=1 for exactly the next cycle.
//     If AUTO_INC, addr<=addr+1, wrapping to 0 when addr+1==NUM_REGS.
//   - UDR with DATA and addr>=NUM_REGS: write ignored, no strobe.
//     If AUTO_INC, addr<=0.
//   - update_strobe is cleared on every cycle with no qualifying write. Back-to-back
//     writes give back-to-back pulses.
//   - CDR/SDR/UDR are exclusive per TAP. If several are asserted together,
//     priority is CDR > SDR > UDR.
//   - Incomplete shift (fewer than DR_WIDTH SDR cycles before UDR): sr holds a
//     partially shifted value and is committed as-is. No length checking.
//   - Reset mid-scan aborts the scan. The next CDR starts clean.
//   - ir_in changes only take effect on the next CDR/SDR/UDR cycle. sr is not
//     cleared on IR change.
// TESTING
//   1 ID read: ir=1, CDR, 8xSDR tdi=0 -> tdo bits 1,0,1,0,0,1,0,1 (8'hA5, LSB first)
//   2 Write: ir=2 shift 8'h02, UDR; ir=3 shift 8'h3C, UDR
//     -> ctrl_out[23:16]=8'h3C, update_strobe 1 cycle, update_addr=2, addr=3
//   3 Wrap + readback: write 8'h11 at addr 3 -> addr=0; DATA CDR, 8xSDR
//     -> tdo shows regs[0]; ADDR readback gives 0
//   4 Out of range (NUM_REGS=3): addr=3, DATA write 8'hFF
//     -> ctrl_out unchanged, no strobe, addr=0; DATA capture returns 0
//   5 STATUS/BYPASS: status_in=8'h5A, ir=4, CDR+8xSDR -> tdo 0,1,0,1,1,0,1,0;
//     ir=0, tdi pattern 1,1,0 -> tdo 0,1,1 (1-cycle delay)
//   6 Reset mid-shift: after 4 SDR on DATA, pulse rst -> ctrl_out=0, addr=0,
//     strobe=0; a following ID read returns 8'hA5

Source files
------------

// File: rtl/vjtag_regbank_if.sv
// Virtual-JTAG hub <-> client signal bundle.
//   tdi                 serial data from hub
//   tdo                 serial data back to hub (driven by the client)
//   ir_in               virtual instruction register
//   virtual_state_cdr   Capture-DR qualifier
//   virtual_state_sdr   Shift-DR qualifier
//   virtual_state_udr   Update-DR qualifier
// master = hub side, slave = register-bank client side.
interface vjtag_regbank_if #(
  parameter int IR_WIDTH = 3
) ();
  logic                tdi;
  logic                tdo;
  logic [IR_WIDTH-1:0] ir_in;
  logic                virtual_state_cdr;
  logic                virtual_state_sdr;
  logic                virtual_state_udr;

  modport master (
    output tdi, ir_in, virtual_state_cdr, virtual_state_sdr, virtual_state_udr,
    input  tdo
  );

  modport slave (
    input  tdi, ir_in, virtual_state_cdr, virtual_state_sdr, virtual_state_udr,
    output tdo
  );
endinterface

// File: rtl/vjtag_regbank.sv
// Virtual-JTAG register bank client.
// Exposes BYPASS, ID, ADDR, DATA and STATUS data registers selected by the
// virtual IR. DATA reads/writes NUM_REGS control registers at the current
// address (optionally auto-incrementing); STATUS captures a fabric word.
// Ports:
//   tck            JTAG clock from the hub; all state updates on posedge
//   rst            asynchronous reset, active-high
//   jtag           hub signal bundle (tdi, tdo, ir_in, CDR/SDR/UDR qualifiers)
//   status_in      fabric status word, sampled on Capture-DR of STATUS
//   ctrl_out       control registers, reg[i] at [i*DR_WIDTH +: DR_WIDTH]
//   update_strobe  one-tck pulse following each accepted DATA write
//   update_addr    address of the most recent accepted DATA write
module vjtag_regbank #(
  parameter int                 IR_WIDTH   = 3,
  parameter int                 DR_WIDTH   = 8,
  parameter int                 NUM_REGS   = 4,
  parameter int                 ADDR_WIDTH = 2,
  parameter logic [DR_WIDTH-1:0] ID_VALUE  = 8'hA5,
  parameter int                 AUTO_INC   = 1
) (
  input  logic                         tck,
  input  logic                         rst,
  vjtag_regbank_if.slave               jtag,
  input  logic [DR_WIDTH-1:0]          status_in,
  output logic [NUM_REGS*DR_WIDTH-1:0] ctrl_out,
  output logic                         update_strobe,
  output logic [ADDR_WIDTH-1:0]        update_addr
);

  localparam logic [IR_WIDTH-1:0] IR_ID     = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IR_ADDR   = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] IR_DATA   = IR_WIDTH'(3);
  localparam logic [IR_WIDTH-1:0] IR_STATUS = IR_WIDTH'(4);

  logic                  bypass_reg;
  logic [DR_WIDTH-1:0]   sr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DR_WIDTH-1:0]   regs [NUM_REGS];

  logic                  sel_sr;
  logic                  addr_in_range;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [DR_WIDTH-1:0]   rd_data;

  // Every code that is not a real data register behaves as BYPASS.
  always_comb begin
    sel_sr = 1'b0;
    case (jtag.ir_in)
      IR_ID, IR_ADDR, IR_DATA, IR_STATUS: sel_sr = 1'b1;
      default:                            sel_sr = 1'b0;
    endcase
  end

  assign jtag.tdo = sel_sr ? sr[0] : bypass_reg;

  always_comb begin
    addr_in_range = (32'(addr) < NUM_REGS);
    if (32'(addr) + 1 == NUM_REGS) begin
      addr_inc = '0;
    end else begin
      addr_inc = addr + ADDR_WIDTH'(1);
    end
  end

  // Out-of-range addresses match no register and read back as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_WIDTH'(i)) rd_data = regs[i];
    end
  end

  always_ff @(posedge tck or posedge rst) begin
    if (rst) begin
      bypass_reg    <= 1'b0;
      sr            <= '0;
      addr          <= '0;
      update_strobe <= 1'b0;
      update_addr   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      update_strobe <= 1'b0;
      // Qualifiers are normally exclusive; if not, capture wins over shift over update.
      if (jtag.virtual_state_cdr) begin
        case (jtag.ir_in)
          IR_ID:     sr <= ID_VALUE;
          IR_ADDR:   sr <= DR_WIDTH'(addr);
          IR_DATA:   sr <= rd_data;
          IR_STATUS: sr <= status_in;
          default:   bypass_reg <= 1'b0;
        endcase
      end else if (jtag.virtual_state_sdr) begin
        if (sel_sr) begin
          sr <= {jtag.tdi, sr[DR_WIDTH-1:1]};
        end else begin
          bypass_reg <= jtag.tdi;
        end
      end else if (jtag.virtual_state_udr) begin
        case (jtag.ir_in)
          IR_ADDR: addr <= sr[ADDR_WIDTH-1:0];
          IR_DATA: begin
            if (addr_in_range) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (addr == ADDR_WIDTH'(i)) regs[i] <= sr;
              end
              update_addr   <= addr;
              update_strobe <= 1'b1;
              if (AUTO_INC != 0) addr <= addr_inc;
            end else if (AUTO_INC != 0) begin
              addr <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl
    assign ctrl_out[g*DR_WIDTH +: DR_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_vjtag_regbank.sv
// Bench for vjtag_regbank: two instances (4 and 3 control registers) are
// driven in lockstep and each is compared against a transaction-level model.
module tb_vjtag_regbank;

  logic       tck = 1'b0;
  logic       rst;
  logic       tdi;
  logic [2:0] ir;
  logic       cdr, sdr, udr;
  logic [7:0] status_in;

  logic [31:0] ctrl_a;
  logic [23:0] ctrl_b;
  logic        strobe_a, strobe_b;
  logic [1:0]  uaddr_a, uaddr_b;
  logic        tdo_a, tdo_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 tck = ~tck;

  vjtag_regbank_if #(.IR_WIDTH(3)) if_a ();
  vjtag_regbank_if #(.IR_WIDTH(3)) if_b ();

  assign if_a.tdi = tdi;  assign if_a.ir_in = ir;
  assign if_a.virtual_state_cdr = cdr;
  assign if_a.virtual_state_sdr = sdr;
  assign if_a.virtual_state_udr = udr;
  assign if_b.tdi = tdi;  assign if_b.ir_in = ir;
  assign if_b.virtual_state_cdr = cdr;
  assign if_b.virtual_state_sdr = sdr;
  assign if_b.virtual_state_udr = udr;
  assign tdo_a = if_a.tdo;
  assign tdo_b = if_b.tdo;

  vjtag_regbank #(.NUM_REGS(4)) dut_a (
    .tck(tck), .rst(rst), .jtag(if_a), .status_in(status_in),
    .ctrl_out(ctrl_a), .update_strobe(strobe_a), .update_addr(uaddr_a)
  );

  vjtag_regbank #(.NUM_REGS(3)) dut_b (
    .tck(tck), .rst(rst), .jtag(if_b), .status_in(status_in),
    .ctrl_out(ctrl_b), .update_strobe(strobe_b), .update_addr(uaddr_b)
  );

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  int         nregs [2] = '{4, 3};
  int         m_addr [2];
  logic [1:0] m_uaddr [2];
  logic [7:0] m_regs [2][4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int d = 0; d < 2; d++) begin
      m_addr[d]  = 0;
      m_uaddr[d] = 2'd0;
      for (int i = 0; i < 4; i++) m_regs[d][i] = 8'h00;
    end
  endfunction

  function automatic logic is_bypass(input logic [2:0] irv);
    return !(irv >= 3'd1 && irv <= 3'd4);
  endfunction

  function automatic logic [7:0] m_capture(input int d, input logic [2:0] irv, input logic [7:0] st);
    case (irv)
      3'd1:    return 8'hA5;
      3'd2:    return 8'(m_addr[d]);
      3'd3:    return (m_addr[d] < nregs[d]) ? m_regs[d][m_addr[d]] : 8'h00;
      3'd4:    return st;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] m_ctrl(input int d);
    logic [31:0] v = '0;
    for (int i = 0; i < nregs[d]; i++) v[i*8 +: 8] = m_regs[d][i];
    return v;
  endfunction

  task automatic check_outputs(input string tag, input logic [1:0] exp_strobe);
    chk({tag, "_strobe_a"}, {31'd0, strobe_a}, {31'd0, exp_strobe[0]});
    chk({tag, "_strobe_b"}, {31'd0, strobe_b}, {31'd0, exp_strobe[1]});
    chk({tag, "_uaddr_a"},  {30'd0, uaddr_a},  {30'd0, m_uaddr[0]});
    chk({tag, "_uaddr_b"},  {30'd0, uaddr_b},  {30'd0, m_uaddr[1]});
    chk({tag, "_ctrl_a"},   ctrl_a,            m_ctrl(0));
    chk({tag, "_ctrl_b"},   {8'd0, ctrl_b},    m_ctrl(1));
  endtask

  // One complete DR scan: CDR, n SDR cycles, optional UDR. Returns on the
  // falling edge after UDR, while any update strobe is still high.
  task automatic scan(input string tag, input logic [2:0] irv, input int n,
                      input logic [7:0] din, input logic do_udr,
                      output logic [7:0] oa, output logic [7:0] ob);
    logic [7:0]  cap [2];
    logic [7:0]  obs [2];
    logic [7:0]  exp_tdo, mask, srf;
    logic [15:0] cat;
    logic [1:0]  exp_strobe;
    obs[0] = 8'h00; obs[1] = 8'h00;
    @(negedge tck);
    ir = irv; cdr = 1'b1; sdr = 1'b0; udr = 1'b0;
    for (int d = 0; d < 2; d++) cap[d] = m_capture(d, irv, status_in);
    for (int k = 0; k < n; k++) begin
      @(negedge tck);
      cdr = 1'b0; sdr = 1'b1; tdi = din[k];
      #1;
      obs[0][k] = tdo_a;
      obs[1][k] = tdo_b;
    end
    @(negedge tck);
    cdr = 1'b0; sdr = 1'b0; udr = do_udr; tdi = 1'b0;
    @(negedge tck);
    udr = 1'b0;
    #1;
    oa = obs[0]; ob = obs[1];
    mask = 8'((16'd1 << n) - 16'd1);
    exp_strobe = 2'b00;
    for (int d = 0; d < 2; d++) begin
      if (is_bypass(irv)) exp_tdo = {din[6:0], 1'b0};
      else                exp_tdo = cap[d];
      if (n > 0) chk({tag, (d == 0) ? "_tdo_a" : "_tdo_b"},
                     {24'd0, obs[d] & mask}, {24'd0, exp_tdo & mask});
      cat = {din, cap[d]} >> n;
      srf = cat[7:0];
      if (do_udr) begin
        if (irv == 3'd2) begin
          m_addr[d] = int'(srf[1:0]);
        end else if (irv == 3'd3) begin
          if (m_addr[d] < nregs[d]) begin
            m_regs[d][m_addr[d]] = srf;
            m_uaddr[d] = 2'(m_addr[d]);
            exp_strobe[d] = 1'b1;
            m_addr[d] = (m_addr[d] + 1 == nregs[d]) ? 0 : m_addr[d] + 1;
          end else begin
            m_addr[d] = 0;
          end
        end
      end
    end
    check_outputs(tag, exp_strobe);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] oa, ob;
    logic [2:0] rir;
    int         rn;
    logic       rudr;

    // Reset state
    rst = 1'b1; tdi = 1'b0; ir = 3'd0; cdr = 1'b0; sdr = 1'b0; udr = 1'b0;
    status_in = 8'h00;
    m_reset();
    repeat (2) @(negedge tck);
    #1;
    check_outputs("reset", 2'b00);
    chk("reset_tdo_a", {31'd0, tdo_a}, 32'd0);
    chk("reset_tdo_b", {31'd0, tdo_b}, 32'd0);
    @(negedge tck);
    rst = 1'b0;

    // ID read
    scan("id", 3'd1, 8, 8'h00, 1'b0, oa, ob);
    chk("id_value", {24'd0, oa}, 32'h0000_00A5);

    // Address then data write
    scan("wr_addr", 3'd2, 8, 8'h02, 1'b1, oa, ob);
    scan("wr_data", 3'd3, 8, 8'h3C, 1'b1, oa, ob);
    chk("wr_reg2", {24'd0, ctrl_a[23:16]}, 32'h3C);
    chk("wr_uaddr2", {30'd0, uaddr_a}, 32'd2);
    @(negedge tck);
    #1;
    check_outputs("strobe_drop", 2'b00);

    // Wrap and readback
    scan("wrap_wr", 3'd3, 8, 8'h11, 1'b1, oa, ob);
    chk("wrap_reg3", {24'd0, ctrl_a[31:24]}, 32'h11);
    scan("wrap_rd", 3'd3, 8, 8'h00, 1'b0, oa, ob);
    scan("addr_rd", 3'd2, 8, 8'h00, 1'b0, oa, ob);
    chk("addr_after_wrap", {24'd0, oa}, 32'd0);

    // Out of range on the 3-register instance
    scan("oor_addr", 3'd2, 8, 8'h03, 1'b1, oa, ob);
    scan("oor_cap", 3'd3, 8, 8'h00, 1'b0, oa, ob);
    chk("oor_cap_b", {24'd0, ob}, 32'd0);
    scan("oor_addr2", 3'd2, 8, 8'h03, 1'b1, oa, ob);
    scan("oor_wr", 3'd3, 8, 8'hFF, 1'b1, oa, ob);
    chk("oor_nostrobe_b", {31'd0, strobe_b}, 32'd0);
    scan("oor_addr_rd", 3'd2, 8, 8'h00, 1'b0, oa, ob);
    chk("oor_addr_zero_b", {24'd0, ob}, 32'd0);

    // STATUS and BYPASS
    status_in = 8'h5A;
    scan("status", 3'd4, 8, 8'h00, 1'b0, oa, ob);
    chk("status_value", {24'd0, oa}, 32'h5A);
    scan("bypass", 3'd0, 3, 8'b0000_0011, 1'b0, oa, ob);
    chk("bypass_delay", {29'd0, oa[2:0]}, 32'b110);

    // Randomised transactions, including partial shifts and unused IR codes
    for (int t = 0; t < 60; t++) begin
      status_in = 8'($urandom);
      rir  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) rir = 3'($urandom_range(2, 3));
      rn   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8;
      rudr = 1'($urandom);
      scan("rand", rir, rn, 8'($urandom), rudr, oa, ob);
    end

    // Reset in the middle of a DATA shift
    @(negedge tck);
    ir = 3'd3; cdr = 1'b1;
    @(negedge tck);
    cdr = 1'b0; sdr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tdi = 1'($urandom);
      @(negedge tck);
    end
    sdr = 1'b0; tdi = 1'b0;
    rst = 1'b1;
    m_reset();
    #1;
    check_outputs("midrst", 2'b00);
    @(negedge tck);
    rst = 1'b0;
    scan("midrst_addr", 3'd2, 8, 8'h00, 1'b0, oa, ob);
    chk("midrst_addr_a", {24'd0, oa}, 32'd0);
    scan("midrst_id", 3'd1, 8, 8'h00, 1'b0, oa, ob);
    chk("midrst_id_a", {24'd0, oa}, 32'hA5);
    chk("midrst_id_b", {24'd0, ob}, 32'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
